// File: rtl/muldiv_issue_ctrl.sv
// Issue sequencer for the multi-cycle multiply/divide units at the EXE/MEM boundary.
// Launches the pipelined multiplier or the iterative divider, stalls the pipe until done, and latches lo/hi.
module muldiv_issue_ctrl #(
    parameter int MULT_LAT = 3,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_start_mult,
    input  logic        i_start_div,
    input  logic        i_signed,
    input  logic [31:0] i_opr1,
    input  logic [31:0] i_opr2,
    input  logic        i_flush,
    output logic        o_mult_issue,
    input  logic [31:0] i_mult_lo,
    input  logic [31:0] i_mult_hi,
    output logic        o_div_start,
    output logic        o_div_cancel,
    input  logic        i_div_done,
    input  logic [31:0] i_div_q,
    input  logic [31:0] i_div_r,
    output logic [31:0] o_opr1,
    output logic [31:0] o_opr2,
    output logic        o_signed,
    output logic        o_stall,
    output logic        o_result_valid,
    output logic [31:0] o_lo,
    output logic [31:0] o_hi
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_MULT_WAIT = 3'd1;
    localparam logic [2:0] S_DIV_ISSUE = 3'd2;
    localparam logic [2:0] S_DIV_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             idle, go_mult, go_div, div_zero, mult_cap, div_cap, busy;

    assign idle     = (state == S_IDLE);
    assign go_mult  = idle && i_start_mult && !i_flush;
    assign go_div   = idle && !i_start_mult && i_start_div && !i_flush;
    assign div_zero = go_div && (i_opr2 == 32'd0);
    // The last MULT_WAIT cycle is the one whose decrement lands on zero.
    assign mult_cap = (state == S_MULT_WAIT) && !i_flush && (cnt == CNT_ONE);
    assign div_cap  = (state == S_DIV_WAIT) && !i_flush && i_div_done;
    assign busy     = (state == S_MULT_WAIT) || (state == S_DIV_ISSUE) || (state == S_DIV_WAIT);

    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start_mult)
                        state_nxt = S_MULT_WAIT;
                    else if (i_start_div)
                        state_nxt = (i_opr2 == 32'd0) ? S_DONE : S_DIV_ISSUE;
                end
                S_MULT_WAIT: if (cnt == CNT_ONE) state_nxt = S_DONE;
                S_DIV_ISSUE: state_nxt = S_DIV_WAIT;
                S_DIV_WAIT:  if (i_div_done) state_nxt = S_DONE;
                S_DONE:      state_nxt = S_IDLE;
                default:     state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            cnt          <= '0;
            o_mult_issue <= 1'b0;
            o_opr1       <= 32'd0;
            o_opr2       <= 32'd0;
            o_signed     <= 1'b0;
            o_lo         <= 32'd0;
            o_hi         <= 32'd0;
        end else begin
            state        <= state_nxt;
            o_mult_issue <= go_mult;

            if (i_flush)
                cnt <= '0;
            else if (go_mult)
                cnt <= CNT_INIT;
            else if (state == S_MULT_WAIT)
                cnt <= cnt - CNT_ONE;

            if (go_mult || (go_div && !div_zero)) begin
                o_opr1   <= i_opr1;
                o_opr2   <= i_opr2;
                o_signed <= i_signed;
            end

            // Divide by zero resolves without the divider: quotient all ones, remainder = dividend.
            if (div_zero) begin
                o_lo <= 32'hFFFF_FFFF;
                o_hi <= i_opr1;
            end else if (mult_cap) begin
                o_lo <= i_mult_lo;
                o_hi <= i_mult_hi;
            end else if (div_cap) begin
                o_lo <= i_div_q;
                o_hi <= i_div_r;
            end
        end
    end

    assign o_stall        = resetn && (busy || (idle && (i_start_mult || i_start_div) && !i_flush));
    assign o_div_start    = (state == S_DIV_ISSUE);
    assign o_div_cancel   = i_flush && ((state == S_DIV_ISSUE) || (state == S_DIV_WAIT));
    assign o_result_valid = (state == S_DONE) && !i_flush;

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Sequences the multi-cycle multiply/divide resources that feed the Mult_lo/hi and Div_quotient/remainder fields of the EXE/MEM boundary.
- Accepts a start from EXE, launches either the pipelined multiplier (fixed latency) or the iterative divider (start/done handshake), and holds the pipeline while the operation is in flight.
- Latches the results for the EXE/MEM register and aborts cleanly on an exception flush.

Parameters:
- MULT_LAT, 3, multiplier pipeline latency in cycles from o_mult_issue to valid i_mult_lo/hi; legal range 1..15.
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > MULT_LAT.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- i_start_mult  in  1  EXE holds a MULT/MULTU this cycle.
- i_start_div  in  1  EXE holds a DIV/DIVU this cycle.
- i_signed  in  1  signed operation; sampled with the start.
- i_opr1  in  32  rs value, dividend or multiplicand.
- i_opr2  in  32  rt value, divisor or multiplier.
- i_flush  in  1  exception or eret flush from MEM; aborts any operation.
- o_mult_issue  out  1  one-cycle pulse launching the multiplier with o_opr1/o_opr2/o_signed.
- i_mult_lo  in  32  multiplier low result.
- i_mult_hi  in  32  multiplier high result.
- o_div_start  out  1  one-cycle pulse launching the divider.
- o_div_cancel  out  1  one-cycle pulse aborting the divider.
- i_div_done  in  1  divider result valid (single-cycle pulse).
- i_div_q  in  32  divider quotient.
- i_div_r  in  32  divider remainder.
- o_opr1  out  32  registered operand 1 to both units.
- o_opr2  out  32  registered operand 2 to both units.
- o_signed  out  1  registered sign mode.
- o_stall  out  1  hold request; when high, the pipeline control deasserts EXE/MEM enable and freezes IF/ID/EXE.
- o_result_valid  out  1  one-cycle pulse; the result registers are updated this cycle.
- o_lo  out  32  latched mult_lo or div_q.
- o_hi  out  32  latched mult_hi or div_r.

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0.
- States: IDLE, MULT_WAIT, DIV_ISSUE, DIV_WAIT, DONE.
- IDLE:
  - On i_start_mult: latch operands and sign; go to MULT_WAIT; counter = MULT_LAT. o_mult_issue pulses in the first MULT_WAIT cycle.
  - On i_start_div with i_opr2 != 0: latch operands and sign; go to DIV_ISSUE.
  - On i_start_div with i_opr2 == 0: go to DONE directly; o_lo = 0xFFFFFFFF, o_hi = i_opr1. The divider is not started.
  - If both starts are high, mult wins and div is ignored.
- o_stall is combinational: high in IDLE whenever a start is high and i_flush is low; high throughout MULT_WAIT, DIV_ISSUE and DIV_WAIT; low in IDLE (no start) and in DONE.
- MULT_WAIT: counter decrements each cycle. When the counter reaches 0, capture i_mult_lo/hi into o_lo/o_hi and go to DONE. The total stall is MULT_LAT+1 cycles.
- DIV_ISSUE: o_div_start = 1 for exactly one cycle; go to DIV_WAIT.
- DIV_WAIT: wait with no timeout. On i_div_done, capture i_div_q/r into o_lo/o_hi and go to DONE. An i_div_done seen in any other state is ignored.
- DONE: o_result_valid = 1 for one cycle with o_stall = 0, so the EXE/MEM register samples o_lo/o_hi on that edge. Return to IDLE. A start seen in DONE is ignored; since the pipeline advances this edge, the next op is accepted in IDLE.
- o_lo/o_hi hold their value until the next capture; flush does not clear them.
- Flush has priority over every transition:
  - Any state goes to IDLE on the next edge.
  - o_div_cancel pulses that cycle if the state is DIV_ISSUE or DIV_WAIT.
  - No o_result_valid is produced for the aborted operation.
  - A start coincident with i_flush in IDLE is dropped and o_stall stays low.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The divider relies on its own reset, so no cancel is issued.
- Width rules: operands pass through unchanged; sign handling lives in the units.

Test Plan:
- MULT 7 x 6, MULT_LAT=3, multiplier model returns lo=42, hi=0 -> o_mult_issue one pulse; o_stall high 4 cycles; o_result_valid one cycle later with o_lo=42, o_hi=0.
- DIVU 100 / 7, divider model done after 33 cycles -> o_div_start one pulse; o_stall held until done; o_lo=14, o_hi=2, o_result_valid one pulse.
- DIV 0x80000000 / 0 -> no o_div_start; DONE next cycle with o_lo=0xFFFFFFFF, o_hi=0x80000000.
- DIV in flight, i_flush asserted in the 10th DIV_WAIT cycle -> o_div_cancel one pulse; IDLE next cycle; o_stall 0; no o_result_valid; o_lo/o_hi unchanged. A late i_div_done is ignored.
- i_start_mult and i_start_div together with opr 3, 5 -> only o_mult_issue; o_lo=15.
- resetn low during MULT_WAIT -> all outputs 0 asynchronously. After release, a fresh MULT 2 x 2 completes with o_lo=4.
